// File: rtl/symbol_feeder_if.sv
// Handshake/data bundle between a symbol_feeder and whatever loads it.
// The loader is the master (start/word/pause); the feeder is the slave.
interface symbol_feeder_if #(
  parameter int WORD_W = 18
) ();
  logic              start;
  logic [WORD_W-1:0] word;
  logic              pause;
  logic [1:0]        a;
  logic              a_valid;
  logic              busy;
  logic              done;
  logic [3:0]        sym_idx;

  modport master (
    output start, word, pause,
    input  a, a_valid, busy, done, sym_idx
  );

  modport slave (
    input  start, word, pause,
    output a, a_valid, busy, done, sym_idx
  );
endinterface

// File: rtl/symbol_feeder.sv
// symbol_feeder: serialises a loaded word into 2-bit symbols on a, each held HOLD un-paused cycles.
// Define SYM_FEEDER_PARITY_EN to append a parity symbol {^odd bits, ^even bits} after the data.
//
// state | meaning
// IDLE  | waiting for start; outputs at idle values
// SEND  | emitting symbols; hold counter advances on cycles with pause=0
// DONE  | single cycle with done=1, busy=1, a_valid=0; then IDLE
module symbol_feeder #(
  parameter int         WORD_W    = 18,
  parameter int         HOLD      = 2,
  parameter bit         MSB_FIRST = 1'b1,
  parameter logic [1:0] IDLE_SYM  = 2'b00
) (
  input  logic           clk,
  input  logic           reset,
  symbol_feeder_if.slave bus
);

  localparam int N_DATA = WORD_W / 2;
`ifdef SYM_FEEDER_PARITY_EN
  localparam int N_SYM = N_DATA + 1;
  localparam logic [3:0] IDX_LAST_DATA = 4'(N_DATA - 1);
`else
  localparam int N_SYM = N_DATA;
`endif
  localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD - 1);
  localparam logic [3:0] IDX_LAST = 4'(N_SYM - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        idx_q, idx_d;
  logic [1:0]        a_q, a_d;
  logic              av_q, av_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef SYM_FEEDER_PARITY_EN
  logic [1:0]        par_q, par_d;
`endif

  function automatic logic [1:0] head_sym(input logic [WORD_W-1:0] v);
    if (MSB_FIRST) return v[WORD_W-1 -: 2];
    else           return v[1:0];
  endfunction

  function automatic logic [WORD_W-1:0] shift_out(input logic [WORD_W-1:0] v);
    if (MSB_FIRST) return v << 2;
    else           return v >> 2;
  endfunction

`ifdef SYM_FEEDER_PARITY_EN
  function automatic logic [1:0] parity_of(input logic [WORD_W-1:0] v);
    logic odd_x, even_x;
    odd_x  = 1'b0;
    even_x = 1'b0;
    for (int i = 0; i < WORD_W; i += 2) begin
      even_x = even_x ^ v[i];
      odd_x  = odd_x ^ v[i+1];
    end
    return {odd_x, even_x};
  endfunction
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      a_q     <= IDLE_SYM;
      av_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SYM_FEEDER_PARITY_EN
      par_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      av_q    <= av_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SYM_FEEDER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    a_d     = a_q;
    av_d    = av_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SYM_FEEDER_PARITY_EN
    par_d   = par_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        a_d    = IDLE_SYM;
        av_d   = 1'b0;
        busy_d = 1'b0;
        idx_d  = '0;
        cnt_d  = '0;
        if (bus.start) begin
          state_d = S_SEND;
          sr_d    = bus.word;
          a_d     = head_sym(bus.word);
          av_d    = 1'b1;
          busy_d  = 1'b1;
`ifdef SYM_FEEDER_PARITY_EN
          par_d   = parity_of(bus.word);
`endif
        end
      end

      S_SEND: begin
        if (!bus.pause) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              av_d    = 1'b0;
              a_d     = IDLE_SYM;
            end else begin
              idx_d = idx_q + 4'd1;
              sr_d  = shift_out(sr_q);
`ifdef SYM_FEEDER_PARITY_EN
              // the symbol after the last data symbol is the parity captured at start
              if (idx_q == IDX_LAST_DATA) a_d = par_q;
              else                        a_d = head_sym(shift_out(sr_q));
`else
              a_d = head_sym(shift_out(sr_q));
`endif
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        idx_d   = '0;
        a_d     = IDLE_SYM;
        av_d    = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        idx_d   = '0;
        a_d     = IDLE_SYM;
        av_d    = 1'b0;
      end
    endcase
  end

  assign bus.a       = a_q;
  assign bus.a_valid = av_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.sym_idx = idx_q;

endmodule

// File: tb/tb_symbol_feeder.sv
// Bench for symbol_feeder: two instances (HOLD=2/MSB first, HOLD=1/LSB first) against a
// timeline model where the shown symbol is (un-paused edges consumed) / HOLD.
module tb_symbol_feeder;

  localparam int W     = 18;
  localparam int NDATA = W / 2;
`ifdef SYM_FEEDER_PARITY_EN
  localparam int NSYM = NDATA + 1;
`else
  localparam int NSYM = NDATA;
`endif
  localparam logic [W-1:0] BASIC_WORD = 18'b010110100110000001;
  localparam logic [W-1:0] ODD_MASK   = 18'h2AAAA;
  localparam logic [W-1:0] EVEN_MASK  = 18'h15555;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  symbol_feeder_if #(.WORD_W(W)) bus0 ();
  symbol_feeder_if #(.WORD_W(W)) bus1 ();

  symbol_feeder #(.WORD_W(W), .HOLD(2), .MSB_FIRST(1'b1), .IDLE_SYM(2'b00)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  symbol_feeder #(.WORD_W(W), .HOLD(1), .MSB_FIRST(1'b0), .IDLE_SYM(2'b00)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic [W-1:0] wd, input logic ps);
    if (sel == 0) begin
      bus0.start = st; bus0.word = wd; bus0.pause = ps;
    end else begin
      bus1.start = st; bus1.word = wd; bus1.pause = ps;
    end
  endtask

  task automatic sample(input int sel, output int a, output int av, output int bz,
                        output int dn, output int ix);
    if (sel == 0) begin
      a = int'(bus0.a); av = int'(bus0.a_valid); bz = int'(bus0.busy);
      dn = int'(bus0.done); ix = int'(bus0.sym_idx);
    end else begin
      a = int'(bus1.a); av = int'(bus1.a_valid); bz = int'(bus1.busy);
      dn = int'(bus1.done); ix = int'(bus1.sym_idx);
    end
  endtask

  // symbol i of the stream; index NDATA is the parity symbol
  function automatic int exp_sym(input int sel, input logic [W-1:0] wd, input int i);
    if (i == NDATA)
      return 2 * ($countones(wd & ODD_MASK) % 2) + ($countones(wd & EVEN_MASK) % 2);
    if (sel == 0) return int'((wd >> (2 * (NDATA - 1 - i))) & 3);
    return int'((wd >> (2 * i)) & 3);
  endfunction

  task automatic check_idle(input int sel, input string tag);
    int a, av, bz, dn, ix;
    sample(sel, a, av, bz, dn, ix);
    check_val({tag, "_a"}, a, 0);
    check_val({tag, "_valid"}, av, 0);
    check_val({tag, "_busy"}, bz, 0);
    check_val({tag, "_done"}, dn, 0);
    check_val({tag, "_idx"}, ix, 0);
  endtask

  // Called and returns at a negedge. pmode: 0 no pause, 1 random pause, 2 three pauses on symbol 3.
  task automatic run_xfer(input int sel, input logic [W-1:0] wd, input int pmode, input bit noise);
    int   hold, total, consumed, cyc, npause, idx3_cnt, pdir, ei;
    int   a, av, bz, dn, ix;
    bit   noise4, got_done;
    logic p, st;
    logic [W-1:0] nw;
    hold = (sel == 0) ? 2 : 1;
    total = NSYM * hold;
    consumed = 0; cyc = 0; npause = 0; idx3_cnt = 0; pdir = 0; ei = 0;
    noise4 = 1'b0; got_done = 1'b0;
    drive(sel, 1'b1, wd, 1'b0);
    @(posedge clk);
    for (int guard = 0; guard < 300 && !got_done; guard++) begin
      @(negedge clk);
      cyc++;
      sample(sel, a, av, bz, dn, ix);
      if (consumed < total) begin
        ei = consumed / hold;
        check_val("sym", a, exp_sym(sel, wd, ei));
        check_val("valid", av, 1);
        check_val("busy", bz, 1);
        check_val("done_early", dn, 0);
        check_val("sym_idx", ix, ei);
        if (ei == 3) idx3_cnt++;
      end else begin
        check_val("done", dn, 1);
        check_val("busy_done", bz, 1);
        check_val("valid_done", av, 0);
        check_val("a_done", a, 0);
        check_val("done_cycle", cyc, total + npause + 1);
        got_done = 1'b1;
      end
      p = 1'b0;
      if (pmode == 1) p = ($urandom_range(3) == 0);
      else if (pmode == 2 && ei == 3 && pdir < 3) begin
        p = 1'b1;
        pdir++;
      end
      st = 1'b0;
      nw = W'($urandom);
      if (pmode == 1 && $urandom_range(7) == 0) st = 1'b1;
      if (noise && ei == 4 && !noise4) begin
        st = 1'b1; nw = '0; noise4 = 1'b1;
      end
      if (noise && got_done) begin
        st = 1'b1; nw = '0;
      end
      drive(sel, st, nw, p);
      @(posedge clk);
      if (consumed < total) begin
        if (p) npause++;
        else   consumed++;
      end
    end
    if (!got_done) check_val("timeout_no_done", 0, 1);
    @(negedge clk);
    check_idle(sel, "after_done");
    if (pmode == 2) check_val("sym3_hold", idx3_cnt, hold + 3);
    drive(sel, 1'b0, '0, 1'b0);
  endtask

  initial begin
    drive(0, 1'b0, '0, 1'b0);
    drive(1, 1'b0, '0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle(0, "rst0");
    check_idle(1, "rst1");
    reset = 1'b1;
    @(negedge clk);
    check_idle(0, "post_rst0");

    // abort mid-transfer; outputs must drop without waiting for a clock edge
    drive(0, 1'b1, BASIC_WORD, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, '0, 1'b0);
    repeat ($urandom_range(14, 2)) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_idle(0, "async_rst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle(0, "abort_no_done");

    run_xfer(0, BASIC_WORD, 0, 1'b0);
    run_xfer(0, BASIC_WORD, 2, 1'b0);
    run_xfer(0, BASIC_WORD, 0, 1'b1);
    run_xfer(0, W'($urandom), 1, 1'b0);
    run_xfer(1, BASIC_WORD, 0, 1'b0);
    run_xfer(1, BASIC_WORD, 2, 1'b1);

    for (int n = 0; n < 12; n++) begin
      run_xfer(0, W'($urandom), 1, 1'($urandom_range(1)));
      run_xfer(1, W'($urandom), 1, 1'($urandom_range(1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
